alu_arbiter_ctrl: RTL and testbench
===================================

// Module: alu_arbiter_ctrl
// PURPOSE
//  Shares one registered 16-bit ALU_TOP instance between two requesters (port 0, port 1).
//  - Round-robin arbitration; valid/ready handshake on each request port.
//  - Drives the ALU operands and ALU_FUN, waits the ALU register latency, then captures the result.
//  - Selects the result and flag of the enabled unit and returns them on one response port with requester ID.
// PARAMETERS
//  Width    16  operand width; result bus is 2*Width
//  ALU_LAT  1   cycles from ALU input change to valid registered ALU output (>=1)
//  CNT_W    16  width of completed-operation counter
// PORTS
//  CLK          in   1        system clock, all state on rising edge
//  RST          in   1        asynchronous, active-low reset
//  req0_valid   in   1        port 0 command valid
//  req0_ready   out  1        port 0 command accepted this cycle (valid&ready)
//  req0_a       in   Width    port 0 operand A (signed)
//  req0_b       in   Width    port 0 operand B (signed)
//  req0_fun     in   4        port 0 ALU_FUN
//  req1_*       -    -        identical set for port 1
//  resp_valid   out  1        result available
//  resp_ready   in   1        consumer takes result
//  resp_id      out  1        requester owning result (0/1)
//  resp_data    out  2*Width  selected unit result, zero-extended if unit is Width wide
//  resp_flag    out  1        selected unit flag sampled at capture
//  resp_err     out  1        1 = selected unit flag was 0 at capture
//  busy         out  1        1 whenever state != IDLE
//  done_cnt     out  CNT_W    completed responses, wraps to 0
//  alu_a/alu_b  out  Width    to ALU A/B (registered)
//  alu_fun      out  4        to ALU ALU_FUN (registered)
//  alu_arith_out in  2*Width  from ALU; alu_logic_out/alu_shift_out/alu_cmp_out in Width
//  alu_arith_flag/alu_logic_flag/alu_shift_flag/alu_cmp_flag  in 1  ALU unit flags
// BEHAVIOUR
//  Reset (RST=0, async): state IDLE, all outputs 0, last_grant=1, wait counter 0; in-flight op discarded.
//  FSM: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
//  IDLE: reqN_ready = grant==N, both combinational from valids/last_grant.
//    Only one valid: that port granted. Both valid: port != last_grant granted.
//    On handshake: latch a/b/fun into alu_a/alu_b/alu_fun; store id; last_grant=id; wcnt=ALU_LAT-1; ->EXEC.
//    Ready never asserted outside IDLE; only one port ready per cycle.
//  EXEC: ALU inputs held; wcnt decrements each cycle; at wcnt==0 -> CAPT (EXEC lasts ALU_LAT cycles).
//  CAPT: sample by alu_fun[3:2]: 00 arith(full 2*Width), 01 logic, 10 cmp, 11 shift
//    (Width-bit results zero-extended); resp_flag=that unit's flag; resp_err=~flag; ->RESP.
//  RESP: resp_valid=1, data/id/flag/err stable until resp_ready=1 (same edge: ->IDLE,
//    resp_valid=0, done_cnt+1 mod 2^CNT_W). Requests wait, never dropped.
//  Latency: handshake edge to resp_valid high = ALU_LAT+2 cycles; min issue interval ALU_LAT+3.
//  alu_a/alu_b/alu_fun keep last command while IDLE (no spurious change).
//  Reset mid-op: FSM to IDLE, resp_valid=0 immediately, done_cnt=0; op not retried.
//  Requester dropping valid before ready: nothing captured, no state change.
// TESTING
//  1 Reset: RST=0 with req0_valid=1 -> all outputs 0, req0_ready=0; release -> req0_ready=1 first cycle.
//  2 Single add: req0 A=5 B=-3 fun=0000 -> resp_valid ALU_LAT+2 cycles later, data=32'd2, id=0, flag=1, err=0.
//  3 Contention: both valid continuously, resp_ready=1 -> grants 0,1,0,1; done_cnt=4 after 4 responses.
//  4 Backpressure: resp_ready=0 for 10 cycles -> resp_* stable, req*_ready=0, busy=1; then resp_ready=1 -> one completion.
//  5 Unit select: logic fun=0100 A=16'h00F0 B=16'h0FF0 -> data=32'h0000_00F0; cmp/shift ops likewise zero-extended.
//  6 Reset in EXEC: assert RST mid-op -> resp_valid never rises, state IDLE, done_cnt=0.

Source files
------------

// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: round-robin front end that shares one registered ALU
// between two requesters and returns the selected unit result with the
// requester ID on a single response port.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for a request; ready offered to the granted port
// S_EXEC | operands held on the ALU, waiting out its register latency
// S_CAPT | ALU output valid; sample the unit picked by alu_fun[3:2]
// S_RESP | response presented until the consumer takes it
module alu_arbiter_ctrl #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic [WIDTH-1:0]     i_req0_a,
  input  logic [WIDTH-1:0]     i_req0_b,
  input  logic [3:0]           i_req0_fun,
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic [WIDTH-1:0]     i_req1_a,
  input  logic [WIDTH-1:0]     i_req1_b,
  input  logic [3:0]           i_req1_fun,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic                 o_resp_id,
  output logic [2*WIDTH-1:0]   o_resp_data,
  output logic                 o_resp_flag,
  output logic                 o_resp_err,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_done_cnt,
  output logic [WIDTH-1:0]     o_alu_a,
  output logic [WIDTH-1:0]     o_alu_b,
  output logic [3:0]           o_alu_fun,
  input  logic [2*WIDTH-1:0]   i_alu_arith_out,
  input  logic [WIDTH-1:0]     i_alu_logic_out,
  input  logic [WIDTH-1:0]     i_alu_shift_out,
  input  logic [WIDTH-1:0]     i_alu_cmp_out,
  input  logic                 i_alu_arith_flag,
  input  logic                 i_alu_logic_flag,
  input  logic                 i_alu_shift_flag,
  input  logic                 i_alu_cmp_flag
);

  localparam int WC_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [WC_W-1:0] WC_INIT = WC_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_RESP} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_grant_vld;
  logic                 w_grant_id;
  logic                 r_last_grant;
  logic                 r_id;
  logic [WC_W-1:0]      r_wcnt;
  logic [WIDTH-1:0]     r_alu_a;
  logic [WIDTH-1:0]     r_alu_b;
  logic [3:0]           r_alu_fun;
  logic [2*WIDTH-1:0]   w_sel_data;
  logic                 w_sel_flag;
  logic [2*WIDTH-1:0]   r_resp_data;
  logic                 r_resp_flag;
  logic                 r_resp_err;
  logic [CNT_W-1:0]     r_done_cnt;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Round-robin grant (IDLE only, suppressed while reset is held) and next state.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_rst_n) begin
          if (i_req0_valid && i_req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = ~r_last_grant;
          end else if (i_req0_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b0;
          end else if (i_req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b1;
          end
        end
        if (w_grant_vld) w_state_nxt = S_EXEC;
      end
      S_EXEC:  if (r_wcnt == '0) w_state_nxt = S_CAPT;
      S_CAPT:  w_state_nxt = S_RESP;
      S_RESP:  if (i_resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pick the unit result named by the held function code; narrow units are zero-extended.
  always_comb begin
    w_sel_data = '0;
    w_sel_flag = 1'b0;
    case (r_alu_fun[3:2])
      2'b00: begin
        w_sel_data = i_alu_arith_out;
        w_sel_flag = i_alu_arith_flag;
      end
      2'b01: begin
        w_sel_data = {{WIDTH{1'b0}}, i_alu_logic_out};
        w_sel_flag = i_alu_logic_flag;
      end
      2'b10: begin
        w_sel_data = {{WIDTH{1'b0}}, i_alu_cmp_out};
        w_sel_flag = i_alu_cmp_flag;
      end
      default: begin
        w_sel_data = {{WIDTH{1'b0}}, i_alu_shift_out};
        w_sel_flag = i_alu_shift_flag;
      end
    endcase
  end

  // Latch the accepted command onto the ALU and run the latency down-counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_fun    <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_wcnt       <= '0;
    end else if (w_grant_vld) begin
      r_alu_a      <= w_grant_id ? i_req1_a   : i_req0_a;
      r_alu_b      <= w_grant_id ? i_req1_b   : i_req0_b;
      r_alu_fun    <= w_grant_id ? i_req1_fun : i_req0_fun;
      r_id         <= w_grant_id;
      r_last_grant <= w_grant_id;
      r_wcnt       <= WC_INIT;
    end else if (r_state == S_EXEC && r_wcnt != '0) begin
      r_wcnt <= r_wcnt - WC_W'(1);
    end
  end

  // Capture the response in CAPT and count completions as the consumer takes them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resp_data <= '0;
      r_resp_flag <= 1'b0;
      r_resp_err  <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      if (r_state == S_CAPT) begin
        r_resp_data <= w_sel_data;
        r_resp_flag <= w_sel_flag;
        r_resp_err  <= ~w_sel_flag;
      end
      if (r_state == S_RESP && i_resp_ready) r_done_cnt <= r_done_cnt + CNT_W'(1);
    end
  end

  assign o_req0_ready = w_grant_vld & ~w_grant_id;
  assign o_req1_ready = w_grant_vld &  w_grant_id;
  assign o_resp_valid = (r_state == S_RESP);
  assign o_busy       = (r_state != S_IDLE);
  assign o_resp_id    = r_id;
  assign o_resp_data  = r_resp_data;
  assign o_resp_flag  = r_resp_flag;
  assign o_resp_err   = r_resp_err;
  assign o_done_cnt   = r_done_cnt;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_fun    = r_alu_fun;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: a registered ALU stub with configurable latency
// feeds the DUT; expected responses come from an operand-level model.
module tb_alu_arbiter_ctrl;

  localparam int W   = 16;
  localparam int LAT = 2;

  typedef struct packed {
    logic [2*W-1:0] ar;
    logic [W-1:0]   lo;
    logic [W-1:0]   cm;
    logic [W-1:0]   sh;
    logic           fa;
    logic           fl;
    logic           fc;
    logic           fs;
  } alu_o_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b1;
  logic req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] req0_fun = '0, req1_fun = '0;
  logic resp_valid, resp_id, resp_flag, resp_err, busy;
  logic [2*W-1:0] resp_data;
  logic [15:0] done_cnt;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0] alu_fun;
  logic [2*W-1:0] alu_arith_out;
  logic [W-1:0] alu_logic_out, alu_shift_out, alu_cmp_out;
  logic alu_arith_flag, alu_logic_flag, alu_shift_flag, alu_cmp_flag;

  int vecs = 0;
  int errs = 0;
  int model_done = 0;
  logic model_last = 1'b1;

  always #5 clk = ~clk;

  alu_arbiter_ctrl #(.WIDTH(W), .ALU_LAT(LAT), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_fun(req0_fun),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_fun(req1_fun),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_id(resp_id),
    .o_resp_data(resp_data), .o_resp_flag(resp_flag), .o_resp_err(resp_err),
    .o_busy(busy), .o_done_cnt(done_cnt),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fun(alu_fun),
    .i_alu_arith_out(alu_arith_out), .i_alu_logic_out(alu_logic_out),
    .i_alu_shift_out(alu_shift_out), .i_alu_cmp_out(alu_cmp_out),
    .i_alu_arith_flag(alu_arith_flag), .i_alu_logic_flag(alu_logic_flag),
    .i_alu_shift_flag(alu_shift_flag), .i_alu_cmp_flag(alu_cmp_flag)
  );

  // Behaviour of every ALU unit for one operand set; fun[1:0] picks the sub-op.
  function automatic alu_o_t alu_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [3:0] f);
    alu_o_t o;
    logic signed [2*W-1:0] sa, sb;
    logic [2*W-1:0] r;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    case (f[1:0])
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = sa * sb;
      default: r = sa + sb + 32'sd1;
    endcase
    o.ar = r;
    o.fa = ~r[2*W-1];
    case (f[1:0])
      2'd0:    o.lo = a & b;
      2'd1:    o.lo = a | b;
      2'd2:    o.lo = a ^ b;
      default: o.lo = ~a;
    endcase
    o.fl = |o.lo;
    case (f[1:0])
      2'd0:    o.cm = {15'd0, ($signed(a) < $signed(b))};
      2'd1:    o.cm = {15'd0, (a == b)};
      2'd2:    o.cm = {15'd0, (a > b)};
      default: o.cm = {15'd0, (a != b)};
    endcase
    o.fc = o.cm[0];
    case (f[1:0])
      2'd0:    o.sh = a << b[3:0];
      2'd1:    o.sh = a >> b[3:0];
      2'd2:    o.sh = $signed(a) >>> b[3:0];
      default: o.sh = {a[W-2:0], a[W-1]};
    endcase
    o.fs = |o.sh;
    return o;
  endfunction

  // Expected response {err, flag, data} for a command.
  function automatic logic [2*W+1:0] model_resp(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [3:0] f);
    alu_o_t o;
    logic [2*W-1:0] d;
    logic fl;
    o = alu_eval(a, b, f);
    case (f[3:2])
      2'b00:   begin d = o.ar;            fl = o.fa; end
      2'b01:   begin d = {16'd0, o.lo};   fl = o.fl; end
      2'b10:   begin d = {16'd0, o.cm};   fl = o.fc; end
      default: begin d = {16'd0, o.sh};   fl = o.fs; end
    endcase
    return {~fl, fl, d};
  endfunction

  // Registered ALU stub with LAT pipeline stages.
  alu_o_t pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= alu_eval(alu_a, alu_b, alu_fun);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_arith_out  = pipe[LAT-1].ar;
  assign alu_logic_out  = pipe[LAT-1].lo;
  assign alu_cmp_out    = pipe[LAT-1].cm;
  assign alu_shift_out  = pipe[LAT-1].sh;
  assign alu_arith_flag = pipe[LAT-1].fa;
  assign alu_logic_flag = pipe[LAT-1].fl;
  assign alu_cmp_flag   = pipe[LAT-1].fc;
  assign alu_shift_flag = pipe[LAT-1].fs;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_done = 0;
    model_last = 1'b1;
  endtask

  // Drives one command on a port and returns at the first cycle resp_valid is seen.
  // lat counts cycles from the handshake cycle (cycle 0).
  task automatic issue_op(input logic port, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] f, output int lat, output logic ok);
    int n;
    logic rdy;
    @(negedge clk);
    if (port) begin req1_a = a; req1_b = b; req1_fun = f; req1_valid = 1'b1; end
    else      begin req0_a = a; req0_b = b; req0_fun = f; req0_valid = 1'b1; end
    #1;
    n = 0;
    rdy = port ? req1_ready : req0_ready;
    while (!rdy && n < 50) begin
      @(negedge clk); #1; n++;
      rdy = port ? req1_ready : req0_ready;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(negedge clk); #1; lat++;
    end
    ok = rdy && resp_valid;
    model_last = port;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req0_a = 16'h1234; req0_b = 16'h5678; req0_fun = 4'h5;
    resp_ready = 1'b1;
    @(negedge clk); #1;
    vecs++;
    if ({req0_ready, req1_ready, resp_valid, resp_id, resp_data, resp_flag, resp_err, busy,
         done_cnt, alu_a, alu_b, alu_fun} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got rdy0=%b rdy1=%b rv=%b id=%b data=%h fl=%b err=%b busy=%b cnt=%0d a=%h b=%h fun=%h expected all 0",
               req0_ready, req1_ready, resp_valid, resp_id, resp_data, resp_flag, resp_err, busy,
               done_cnt, alu_a, alu_b, alu_fun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vecs++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_release_ready: got rdy0=%b rdy1=%b expected 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    #1;
    vecs++;
    if (req0_ready !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL drop_valid: got rdy0=%b busy=%b expected 0 0", req0_ready, busy);
    end
    model_done = 0;
    model_last = 1'b1;
  endtask

  task automatic test_single_add();
    int lat;
    logic ok;
    resp_ready = 1'b1;
    issue_op(1'b0, 16'd5, 16'hFFFD, 4'b0000, lat, ok);
    vecs++;
    if (!ok || lat != LAT + 2) begin
      errs++;
      $display("FAIL add_latency: got ok=%b lat=%0d expected lat=%0d", ok, lat, LAT + 2);
    end
    vecs++;
    if (resp_data !== 32'd2 || resp_id !== 1'b0 || resp_flag !== 1'b1 || resp_err !== 1'b0) begin
      errs++;
      $display("FAIL add_result: got data=%h id=%b fl=%b err=%b expected 00000002 0 1 0",
               resp_data, resp_id, resp_flag, resp_err);
    end
    model_done++;
    @(negedge clk); #1;
    vecs++;
    if (resp_valid !== 1'b0 || done_cnt !== 16'(model_done) || busy !== 1'b0) begin
      errs++;
      $display("FAIL add_complete: got rv=%b cnt=%0d busy=%b expected 0 %0d 0",
               resp_valid, done_cnt, busy, model_done);
    end
  endtask

  task automatic test_contention();
    logic [2*W+2:0] q[$];
    logic [2*W+2:0] e;
    logic ref0, ref1, g, eg;
    int grants, resps, n;
    do_reset();
    ref0 = 1'b1; ref1 = 1'b1;
    grants = 0; resps = 0; n = 0;
    resp_ready = 1'b1;
    while (resps < 4 && n < 80) begin
      @(negedge clk);
      if (ref0) begin req0_a = 16'($urandom); req0_b = 16'($urandom); req0_fun = 4'($urandom); end
      if (ref1) begin req1_a = 16'($urandom); req1_b = 16'($urandom); req1_fun = 4'($urandom); end
      ref0 = 1'b0; ref1 = 1'b0;
      if (grants < 4) begin req0_valid = 1'b1; req1_valid = 1'b1; end
      #1;
      if (req0_ready || req1_ready) begin
        g  = req1_ready;
        eg = 1'(grants % 2);
        vecs++;
        if ((req0_ready && req1_ready) || g !== eg) begin
          errs++;
          $display("FAIL contention_grant: grant #%0d got rdy0=%b rdy1=%b expected port %0d",
                   grants, req0_ready, req1_ready, eg);
        end
        if (g) begin q.push_back({1'b1, model_resp(req1_a, req1_b, req1_fun)}); ref1 = 1'b1; end
        else   begin q.push_back({1'b0, model_resp(req0_a, req0_b, req0_fun)}); ref0 = 1'b1; end
        grants++;
      end
      if (resp_valid) begin
        vecs++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL contention_resp: got unexpected response id=%b expected none", resp_id);
        end else begin
          e = q.pop_front();
          if ({resp_id, resp_err, resp_flag, resp_data} !== e) begin
            errs++;
            $display("FAIL contention_resp: got id=%b err=%b fl=%b data=%h expected id=%b err=%b fl=%b data=%h",
                     resp_id, resp_err, resp_flag, resp_data, e[2*W+2], e[2*W+1], e[2*W], e[2*W-1:0]);
          end
        end
        resps++;
        model_done++;
        if (resps == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk); #1;
    vecs++;
    if (resps != 4 || grants != 4 || done_cnt !== 16'd4) begin
      errs++;
      $display("FAIL contention_count: got resps=%0d grants=%0d cnt=%0d expected 4 4 4",
               resps, grants, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat, n;
    logic ok;
    logic [2*W+1:0] e;
    logic [W-1:0] a, b;
    logic [3:0] f;
    a = 16'($urandom); b = 16'($urandom); f = 4'b0001;
    e = model_resp(a, b, f);
    resp_ready = 1'b0;
    issue_op(1'b1, a, b, f, lat, ok);
    req0_a = 16'h0003; req0_b = 16'h0004; req0_fun = 4'b0000;
    req0_valid = 1'b1;
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL bp_issue: got no response within bound expected response");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      vecs++;
      if (resp_valid !== 1'b1 || {resp_err, resp_flag, resp_data} !== e || resp_id !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL bp_hold: cycle %0d got rv=%b id=%b err=%b fl=%b data=%h rdy=%b%b busy=%b expected 1 1 %b %b %h 00 1",
                 i, resp_valid, resp_id, resp_err, resp_flag, resp_data, req0_ready, req1_ready, busy,
                 e[2*W+1], e[2*W], e[2*W-1:0]);
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    model_done++;
    @(negedge clk); #1;
    vecs++;
    if (resp_valid !== 1'b0 || done_cnt !== 16'(model_done) || req0_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_release: got rv=%b cnt=%0d rdy0=%b expected 0 %0d 1",
               resp_valid, done_cnt, req0_ready, model_done);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    model_last = 1'b0;
    #1;
    n = 1;
    while (!resp_valid && n < 50) begin @(negedge clk); #1; n++; end
    vecs++;
    if (resp_valid !== 1'b1 || resp_data !== 32'd7 || resp_id !== 1'b0) begin
      errs++;
      $display("FAIL bp_waiting_req: got rv=%b data=%h id=%b expected 1 00000007 0",
               resp_valid, resp_data, resp_id);
    end
    model_done++;
  endtask

  task automatic test_unit_select();
    logic [W-1:0] ta [6];
    logic [W-1:0] tb_ [6];
    logic [3:0] tf [6];
    logic [2*W+1:0] e;
    int lat;
    logic ok;
    ta[0] = 16'h00F0; tb_[0] = 16'h0FF0; tf[0] = 4'b0100;
    ta[1] = 16'hFFF0; tb_[1] = 16'h0003; tf[1] = 4'b1000;
    ta[2] = 16'h8001; tb_[2] = 16'h0004; tf[2] = 4'b1110;
    ta[3] = 16'h00AA; tb_[3] = 16'h00AA; tf[3] = 4'b1001;
    ta[4] = 16'hFED4; tb_[4] = 16'h00C8; tf[4] = 4'b0010;
    ta[5] = 16'h1234; tb_[5] = 16'h0000; tf[5] = 4'b1100;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = model_resp(ta[i], tb_[i], tf[i]);
      if (i == 0) e[2*W-1:0] = 32'h0000_00F0;
      if (i == 4) e[2*W-1:0] = 32'hFFFF_15A0;
      issue_op(1'b0, ta[i], tb_[i], tf[i], lat, ok);
      vecs++;
      if (!ok || {resp_err, resp_flag, resp_data} !== e || resp_id !== 1'b0) begin
        errs++;
        $display("FAIL unit_select[%0d]: got ok=%b err=%b fl=%b data=%h expected err=%b fl=%b data=%h",
                 i, ok, resp_err, resp_flag, resp_data, e[2*W+1], e[2*W], e[2*W-1:0]);
      end
      model_done++;
    end
  endtask

  task automatic test_reset_exec();
    int n;
    logic seen;
    resp_ready = 1'b1;
    @(negedge clk);
    req0_a = 16'd9; req0_b = 16'd1; req0_fun = 4'b0000; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    vecs++;
    if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_exec_pre: got busy=%b rv=%b expected 1 0", busy, resp_valid);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 16'd0 || alu_a !== '0) begin
      errs++;
      $display("FAIL rst_exec_now: got rv=%b busy=%b cnt=%0d alu_a=%h expected 0 0 0 0",
               resp_valid, busy, done_cnt, alu_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_done = 0;
    model_last = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    vecs++;
    if (seen || done_cnt !== 16'd0) begin
      errs++;
      $display("FAIL rst_exec_after: got activity=%b cnt=%0d expected 0 0", seen, done_cnt);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a [2];
    logic [W-1:0] b [2];
    logic [3:0] f [2];
    logic v [2];
    logic inflight, e0, e1, eid, erv;
    logic [2*W+1:0] e;
    int issue, cyc;
    do_reset();
    v[0] = 1'b0; v[1] = 1'b0;
    inflight = 1'b0; issue = 0; eid = 1'b0; e = '0;
    for (cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!v[p] && $urandom_range(0, 2) == 0) begin
          v[p] = 1'b1;
          a[p] = 16'($urandom); b[p] = 16'($urandom); f[p] = 4'($urandom);
        end else if (v[p] && $urandom_range(0, 7) == 0) begin
          v[p] = 1'b0;
        end
      end
      req0_valid = v[0]; req0_a = a[0]; req0_b = b[0]; req0_fun = f[0];
      req1_valid = v[1]; req1_a = a[1]; req1_b = b[1]; req1_fun = f[1];
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e0 = !inflight && v[0] && (!v[1] || model_last);
      e1 = !inflight && v[1] && (!v[0] || !model_last);
      vecs++;
      if (req0_ready !== e0 || req1_ready !== e1) begin
        errs++;
        $display("FAIL rand_ready: cyc %0d got %b%b expected %b%b", cyc, req0_ready, req1_ready, e0, e1);
      end
      erv = inflight && (cyc >= issue + LAT + 2);
      vecs++;
      if (resp_valid !== erv || done_cnt !== 16'(model_done)) begin
        errs++;
        $display("FAIL rand_resp_valid: cyc %0d got rv=%b cnt=%0d expected rv=%b cnt=%0d",
                 cyc, resp_valid, done_cnt, erv, model_done);
      end
      if (erv) begin
        vecs++;
        if ({resp_id, resp_err, resp_flag, resp_data} !== {eid, e}) begin
          errs++;
          $display("FAIL rand_resp_data: cyc %0d got id=%b err=%b fl=%b data=%h expected id=%b err=%b fl=%b data=%h",
                   cyc, resp_id, resp_err, resp_flag, resp_data, eid, e[2*W+1], e[2*W], e[2*W-1:0]);
        end
        if (resp_ready) begin
          inflight = 1'b0;
          model_done++;
        end
      end
      if (e0 || e1) begin
        eid = e1;
        e = model_resp(a[e1], b[e1], f[e1]);
        inflight = 1'b1;
        issue = cyc;
        model_last = e1;
        v[e1] = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (LAT + 4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_unit_select();
    test_reset_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
